ray_gen: RTL and testbench
==========================

# ray_gen

Per-pixel primary-ray generator for the fixed-point ray tracer. On a start pulse it walks every pixel of the frame in raster order and emits one camera-space `vec3` direction per pixel, unnormalized, over a valid/ready stream. It sits directly upstream of the vec3 normalization stage, which consumes `dir_out` as its input vector. Pixel coordinates travel alongside each ray so downstream stages can address the framebuffer.

## Interface
Parameters:
- `H_RES`, default 320: pixels per row; even, ≥ 2.
- `V_RES`, default 180: rows per frame; even, ≥ 2.
- `PIX_STEP`, default 32'h0000_0100: signed fixed-point (Q16.16) spacing between adjacent pixel rays.
- `FOCAL`, default 32'h0001_0000: Q16.16 constant z component of every ray.

Ports (one clock; reset is asynchronous and active-low):
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous active-low reset.
- `start_in`  in  1  single-cycle frame start request.
- `ready_in`  in  1  downstream (normalizer) can accept a ray.
- `valid_out`  out  1  `dir_out`/`px_out`/`py_out` hold a valid ray.
- `dir_out`  out  96  `vec3`: x [95:64], y [63:32], z [31:0], each Q16.16 signed.
- `px_out`  out  $clog2(H_RES)  pixel column.
- `py_out`  out  $clog2(V_RES)  pixel row.
- `last_out`  out  1  high with the final pixel (H_RES-1, V_RES-1).
- `busy_out`  out  1  frame in progress.
- `frame_done_out`  out  1  one-cycle pulse after the last ray is accepted.

## Operation
- States: IDLE, EMIT.
- IDLE:
  - `valid_out`=0.
  - `start_in`=1 loads px=0, py=0, x=X0, y=Y0 and enters EMIT.
  - X0 = −(H_RES/2)·PIX_STEP; Y0 = (V_RES/2)·PIX_STEP. Both are elaboration-time constants.
- EMIT:
  - `valid_out`=1.
  - The handshake fires on `valid_out && ready_in`.
  - On handshake, not end of row: px+1, x += PIX_STEP.
  - On handshake at end of row (px=H_RES-1): px=0, x=X0, py+1, y −= PIX_STEP.
  - On handshake when `last_out`=1: go to IDLE and pulse `frame_done_out` next cycle.
- Incremental adds only; no multipliers. x and y are 32-bit two's-complement and wrap silently.
- z is always `FOCAL`.
- `start_in` is ignored outside IDLE.
- When `start_in` coincides with the `frame_done_out` cycle, it is accepted: the FSM is already in IDLE.
- `ready_in` low: all outputs hold stable. `valid_out` never drops once raised until its handshake.
- `busy_out` = (state == EMIT).

## Timing
- All outputs are registered.
- Reset values: `valid_out`=0, `dir_out`=0, `px_out`=0, `py_out`=0, `last_out`=0, `busy_out`=0, `frame_done_out`=0. State=IDLE.
- `start_in` sampled at edge N gives `valid_out`=1 after edge N with pixel (0,0).
- Throughput: one ray per cycle while `ready_in`=1. A full frame takes H_RES·V_RES cycles with no stalls.
- `frame_done_out` is high for exactly the cycle after the final handshake edge.
- Reset asserted mid-frame: immediate return to reset values, with no partial output. After deassertion, a new `start_in` is required.

## Configuration
- `RAY_GEN_JITTER_EN` defined:
  - A 16-bit Galois LFSR (poly 0xB400, seed 0xACE1, reset to seed) advances once per handshake.
  - LFSR[7:0] is added as an unsigned offset to the x component output.
  - LFSR[15:8] is added as an unsigned offset to the y component output.
  - Scale is raw LSBs, so jitter stays < 1/256.
  - The internal x/y accumulators are unaffected.
- Not defined: no LFSR; outputs are exact grid values.
- Test plan values below assume the macro is undefined.

## Test plan
All scenarios use H_RES=4, V_RES=2, PIX_STEP=32'h1000, FOCAL=32'h10000, `ready_in`=1 unless noted.
- Reset then `start_in` pulse → next cycle `valid_out`=1, px=0, py=0, `dir_out`={32'hFFFF_E000, 32'h0000_1000, 32'h0001_0000}, `busy_out`=1.
- Full frame at `ready_in`=1 → exactly 8 consecutive valid cycles in raster order. The last ray is (3,1) with x=32'h1000, y=0 and `last_out`=1. The following cycle has `frame_done_out`=1, `valid_out`=0, `busy_out`=0.
- `ready_in` toggled 1,0,0,1 during EMIT → outputs held bit-identical while low. No pixel is skipped or duplicated; total accepted count is 8.
- `start_in` pulsed at pixel (2,0) → ignored: frame continues to (3,1) and only one `frame_done_out` pulse occurs.
- `rst_n_in` asserted at pixel (1,1) → all outputs 0 without waiting for a clock edge. A later `start_in` restarts at (0,0) with x=32'hFFFF_E000.
- With `RAY_GEN_JITTER_EN`: first ray x = 32'hFFFF_E000 + 8'hE1, y = 32'h1000 + 8'hAC. Over the frame, each component stays within 255 LSBs of its grid value.

Source files
------------

// File: rtl/ray_gen.sv
// Raster-order primary-ray generator: one unnormalized camera-space vec3 per pixel.
// Optional RAY_GEN_JITTER_EN adds LFSR sub-pixel jitter to the x/y outputs.
module ray_gen #(
    parameter int          H_RES    = 320,
    parameter int          V_RES    = 180,
    parameter logic [31:0] PIX_STEP = 32'h0000_0100,
    parameter logic [31:0] FOCAL    = 32'h0001_0000
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     start_in,
    input  logic                     ready_in,
    output logic                     valid_out,
    output logic [95:0]              dir_out,
    output logic [$clog2(H_RES)-1:0] px_out,
    output logic [$clog2(V_RES)-1:0] py_out,
    output logic                     last_out,
    output logic                     busy_out,
    output logic                     frame_done_out
);

    localparam int PX_W = $clog2(H_RES);
    localparam int PY_W = $clog2(V_RES);

    localparam logic [PX_W-1:0] PX_MAX = PX_W'(H_RES - 1);
    localparam logic [PY_W-1:0] PY_MAX = PY_W'(V_RES - 1);

    localparam logic [31:0] X0 = 32'd0 - 32'(H_RES / 2) * PIX_STEP;
    localparam logic [31:0] Y0 = 32'(V_RES / 2) * PIX_STEP;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;
    logic [31:0]     x_q, x_d;
    logic [31:0]     y_q, y_d;
    logic [95:0]     dir_q, dir_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            load;
    logic            hs;
    logic [31:0]     jit_x;
    logic [31:0]     jit_y;

    assign hs = (state_q == EMIT) && ready_in;

`ifdef RAY_GEN_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (hs) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Jitter uses the value that will be current while the new ray is shown.
    assign jit_x = {24'd0, lfsr_d[7:0]};
    assign jit_y = {24'd0, lfsr_d[15:8]};
`else
    assign jit_x = 32'd0;
    assign jit_y = 32'd0;
`endif

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = EMIT;
                    px_d    = '0;
                    py_d    = '0;
                    x_d     = X0;
                    y_d     = Y0;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (ready_in) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (px_q == PX_MAX) begin
                            px_d = '0;
                            x_d  = X0;
                            py_d = py_q + PY_W'(1);
                            y_d  = y_q - PIX_STEP;
                        end else begin
                            px_d = px_q + PX_W'(1);
                            x_d  = x_q + PIX_STEP;
                        end
                    end
                end
            end
        endcase

        last_d = (state_d == EMIT) && (px_d == PX_MAX) && (py_d == PY_MAX);

        if (load) begin
            dir_d = {x_d + jit_x, y_d + jit_y, FOCAL};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign valid_out      = (state_q == EMIT);
    assign busy_out       = (state_q == EMIT);
    assign dir_out        = dir_q;
    assign px_out         = px_q;
    assign py_out         = py_q;
    assign last_out       = last_q;
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_ray_gen.sv
// Scoreboard bench for ray_gen: random backpressure, mid-frame start/reset.
// Expected rays come from a closed-form grid model (x = X0 + px*step).
module tb_ray_gen;

    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam int          STEP = 32'h1000;
    localparam logic [31:0] FOC  = 32'h0001_0000;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic        ready_in = 1'b1;
    logic        valid_out;
    logic [95:0] dir_out;
    logic [1:0]  px_out;
    logic        py_out;
    logic        last_out;
    logic        busy_out;
    logic        frame_done_out;

    ray_gen #(
        .H_RES(H),
        .V_RES(V),
        .PIX_STEP(32'h1000),
        .FOCAL(FOC)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .start_in(start_in),
        .ready_in(ready_in),
        .valid_out(valid_out),
        .dir_out(dir_out),
        .px_out(px_out),
        .py_out(py_out),
        .last_out(last_out),
        .busy_out(busy_out),
        .frame_done_out(frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          px;
        int          py;
        logic [95:0] dir;
        bit          last;
    } ray_t;

    ray_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   rdy_mode = 1'b0;
    bit   model_busy = 1'b0;
    bit   done_pend = 1'b0;
    bit   stall_prev = 1'b0;
    logic [100:0] snap;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] grid_dir(input int px, input int py);
        int x;
        int y;
        x = -(H / 2) * STEP + px * STEP;
        y = (V / 2) * STEP - py * STEP;
        return {32'(x), 32'(y), FOC};
    endfunction

    always @(posedge clk_in) begin
        #1;
        ready_in = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: model frame acceptance, pop and compare on each handshake.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            sb.delete();
            model_busy = 1'b0;
            done_pend  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (done_pend || frame_done_out)
                chk("frame_done", 128'(frame_done_out), 128'(done_pend));
            done_pend = 1'b0;
            if (stall_prev)
                chk("hold", 128'({valid_out, last_out, px_out, py_out, dir_out}),
                    128'(snap));
            chk("valid", 128'(valid_out), 128'(model_busy));
            stall_prev = valid_out && !ready_in;
            snap = {valid_out, last_out, px_out, py_out, dir_out};
            if (start_in && !model_busy) begin
                for (int y = 0; y < V; y++)
                    for (int x = 0; x < H; x++)
                        sb.push_back('{x, y, grid_dir(x, y),
                                       (x == H - 1) && (y == V - 1)});
                model_busy = 1'b1;
            end else if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(1), 128'(0));
                end else begin
                    ray_t e;
                    e = sb.pop_front();
                    chk("px", 128'(px_out), 128'(e.px));
                    chk("py", 128'(py_out), 128'(e.py));
                    chk("dir", 128'(dir_out), 128'(e.dir));
                    chk("last", 128'(last_out), 128'(e.last));
                    if (e.last) begin
                        done_pend  = 1'b1;
                        model_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done_out && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_first(input string tag);
        chk({tag, "_valid"}, 128'(valid_out), 128'(1));
        chk({tag, "_busy"}, 128'(busy_out), 128'(1));
        chk({tag, "_pxpy"}, 128'({px_out, py_out}), 128'(0));
        chk({tag, "_dir"}, 128'(dir_out),
            128'({32'hFFFF_E000, 32'h0000_1000, 32'h0001_0000}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        repeat (3) tick();
        chk("rst_async_zero", 128'({valid_out, dir_out, px_out, py_out, last_out,
            busy_out, frame_done_out}), 128'(0));
        rst_n_in = 1'b1;
        tick();
        chk("rst_valid", 128'(valid_out), 128'(0));
        chk("rst_busy", 128'(busy_out), 128'(0));
        chk("rst_dir", 128'(dir_out), 128'(0));
        chk("rst_pos", 128'({px_out, py_out, last_out, frame_done_out}), 128'(0));

        // Frame 1: no stalls, exactly H*V valid cycles.
        pulse_start();
        check_first("f1");
        n = 0;
        while (!frame_done_out && n < 100) begin
            if (valid_out) n++;
            tick();
        end
        chk("f1_valid_cycles", 128'(n), 128'(H * V));
        chk("f1_done", 128'(frame_done_out), 128'(1));
        chk("f1_idle", 128'({valid_out, busy_out}), 128'(0));

        // Frame 2: random stalls; start at pixel (2,0) must be ignored.
        tick();
        rdy_mode = 1'b1;
        pulse_start();
        n = 0;
        while (!(valid_out && px_out == 2 && py_out == 0) && n < 100) begin
            tick();
            n++;
        end
        chk("f2_reach_20", 128'(n < 100), 128'(1));
        pulse_start();
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            if (frame_done_out) pulses++;
            tick();
        end
        chk("f2_done_pulses", 128'(pulses), 128'(1));
        chk("f2_idle", 128'(busy_out), 128'(0));

        // Frame 3: asynchronous reset at pixel (1,1).
        rdy_mode = 1'b0;
        tick();
        pulse_start();
        n = 0;
        while (!(valid_out && px_out == 1 && py_out == 1) && n < 100) begin
            tick();
            n++;
        end
        chk("f3_reach_11", 128'(n < 100), 128'(1));
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("f3_async_rst", 128'({valid_out, dir_out, px_out, py_out, last_out,
            busy_out, frame_done_out}), 128'(0));
        tick();
        rst_n_in = 1'b1;
        repeat (3) tick();
        chk("f3_needs_start", 128'(valid_out), 128'(0));
        pulse_start();
        check_first("f3");
        wait_done();

        // Random frames, some restarted in the frame_done cycle.
        rdy_mode = 1'b1;
        for (int f = 0; f < 6; f++) begin
            if (f[0]) repeat ($urandom_range(0, 3)) tick();
            pulse_start();
            wait_done();
        end
        repeat (4) tick();
        chk("sb_empty", 128'(sb.size()), 128'(0));
        chk("end_idle", 128'({valid_out, busy_out}), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
